// File: rtl/gpi_debounce.sv
// Debounces raw board inputs into clk_sys_i: 2-FF synchroniser plus per-bit stability counter.
// Optional edge pulses and sticky IRQ are built only when GPI_DEBOUNCE_EDGE_IRQ_EN is defined.
module gpi_debounce #(
  parameter int unsigned Width          = 8,
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_ni,
  input  logic [Width-1:0] gp_raw_i,
  output logic [Width-1:0] gp_o,
  output logic [Width-1:0] rise_o,
  output logic [Width-1:0] fall_o,
  input  logic [Width-1:0] irq_mask_i,
  input  logic             irq_clr_i,
  output logic             irq_o
);

  localparam int unsigned CntWidth = $clog2(DebounceCycles + 1);
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

  logic [Width-1:0]                sync1_q, sync_q;
  logic [Width-1:0]                gp_q, gp_d;
  logic [Width-1:0][CntWidth-1:0]  cnt_q, cnt_d;
  logic [Width-1:0]                upd;

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      sync1_q <= '0;
      sync_q  <= '0;
    end else begin
      sync1_q <= gp_raw_i;
      sync_q  <= sync1_q;
    end
  end

  // Any sample equal to the current output restarts that bit's count.
  always_comb begin
    gp_d  = gp_q;
    cnt_d = '0;
    upd   = '0;
    for (int i = 0; i < int'(Width); i++) begin
      if (sync_q[i] != gp_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          upd[i]  = 1'b1;
          gp_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntWidth'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      gp_q  <= '0;
      cnt_q <= '0;
    end else begin
      gp_q  <= gp_d;
      cnt_q <= cnt_d;
    end
  end

  assign gp_o = gp_q;

`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
  logic [Width-1:0] rise_q, rise_d, fall_q, fall_d;
  logic             irq_q, irq_d, irq_set;

  always_comb begin
    rise_d  = upd & sync_q;
    fall_d  = upd & ~sync_q;
    irq_set = |((rise_d | fall_d) & irq_mask_i);
    irq_d   = irq_q;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      rise_q <= '0;
      fall_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      irq_q  <= irq_d;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign irq_o  = irq_q;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ^{irq_mask_i, irq_clr_i, upd};
  assign rise_o = '0;
  assign fall_o = '0;
  assign irq_o  = 1'b0;
`endif

endmodule

// File: tb/tb_gpi_debounce.sv
// Bench for gpi_debounce (Width=8, DebounceCycles=4): window-based model plus directed literal checks.
module tb_gpi_debounce;

  localparam int D = 4;
`ifdef GPI_DEBOUNCE_EDGE_IRQ_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] gp_raw;
  logic [7:0] gp_o, rise_o, fall_o;
  logic [7:0] irq_mask;
  logic       irq_clr;
  logic       irq_o;

  int checks   = 0;
  int failures = 0;

  gpi_debounce #(.Width(8), .DebounceCycles(D)) dut (
    .clk_sys_i  (clk),
    .rst_sys_ni (rst_n),
    .gp_raw_i   (gp_raw),
    .gp_o       (gp_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_mask_i (irq_mask),
    .irq_clr_i  (irq_clr),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Model: output takes value v once the synchronised input (raw delayed two
  // edges) has shown v, different from the output, for the last D samples.
  logic [7:0] hist[$];
  logic [7:0] m_gp, m_rise, m_fall;
  logic       m_irq;

  function automatic logic [7:0] hist_at(input int idx);
    if (idx < 0) return 8'h00;
    return hist[idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      m_gp = 8'h00; m_rise = 8'h00; m_fall = 8'h00; m_irq = 1'b0;
    end else begin
      logic [7:0] flips;
      int e;
      hist.push_back(gp_raw);
      e = hist.size() - 1;
      flips = 8'h00;
      for (int i = 0; i < 8; i++) begin
        logic v;
        bit   stable;
        v = hist_at(e - 2)[i];
        stable = 1'b1;
        for (int k = 0; k < D; k++)
          if (hist_at(e - 2 - k)[i] != v) stable = 1'b0;
        if (stable && (v != m_gp[i])) flips[i] = 1'b1;
      end
      if (EDGE_EN) begin
        m_rise = flips & ~m_gp;
        m_fall = flips & m_gp;
        if (|(flips & irq_mask)) m_irq = 1'b1;
        else if (irq_clr)        m_irq = 1'b0;
      end
      m_gp = m_gp ^ flips;
    end
  end

  always @(negedge clk) begin
    chk("cmp_gp",   gp_o,   m_gp);
    chk("cmp_rise", rise_o, m_rise);
    chk("cmp_fall", fall_o, m_fall);
    chk("cmp_irq",  {7'b0, irq_o}, {7'b0, m_irq});
  end

  // Returns 2 time units after the n-th following posedge; inputs set here are
  // sampled at the next posedge.
  task automatic at_edge(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; gp_raw = 8'hFF; irq_mask = 8'h00; irq_clr = 1'b0;
    at_edge(3);
    chk("reset_gp",  gp_o, 8'h00);
    chk("reset_irq", {7'b0, irq_o}, 8'h00);
    rst_n = 1'b1;
    at_edge(5);
    chk("release_edge4_gp", gp_o, 8'h00);
    at_edge(1);
    chk("release_edge5_gp", gp_o, 8'hFF);
    chk("release_rise", rise_o, EDGE_EN ? 8'hFF : 8'h00);
    chk("release_irq_masked", {7'b0, irq_o}, 8'h00);

    gp_raw = 8'h00;
    at_edge(6);
    chk("all_low_gp", gp_o, 8'h00);

    // clean step
    gp_raw = 8'h01;
    at_edge(5);
    chk("step_edge4_gp", gp_o, 8'h00);
    at_edge(1);
    chk("step_edge5_gp", gp_o, 8'h01);

    // short pulse on bit3
    gp_raw = 8'h09;
    at_edge(3);
    gp_raw = 8'h01;
    at_edge(8);
    chk("short_pulse_gp", gp_o, 8'h01);

    // bounce on bit0
    gp_raw = 8'h00;
    at_edge(6);
    gp_raw = 8'h01; at_edge(2);
    gp_raw = 8'h00; at_edge(2);
    gp_raw = 8'h01;
    at_edge(5);
    chk("bounce_edge4_gp", gp_o, 8'h00);
    at_edge(1);
    chk("bounce_edge5_gp", gp_o, 8'h01);

    // independence, bit2 unmasked
    irq_mask = 8'h04;
    gp_raw = 8'h05;
    at_edge(2);
    gp_raw = 8'h25;
    at_edge(4);
    chk("indep_edge5_gp", gp_o, 8'h05);
    chk("indep_rise2", rise_o, EDGE_EN ? 8'h04 : 8'h00);
    chk("indep_irq_set", {7'b0, irq_o}, EDGE_EN ? 8'h01 : 8'h00);
    at_edge(1);
    chk("indep_edge6_gp", gp_o, 8'h05);
    chk("indep_rise_gone", rise_o, 8'h00);
    at_edge(1);
    chk("indep_edge7_gp", gp_o, 8'h25);
    chk("indep_irq_held", {7'b0, irq_o}, EDGE_EN ? 8'h01 : 8'h00);

    irq_clr = 1'b1; at_edge(1); irq_clr = 1'b0;
    chk("irq_cleared", {7'b0, irq_o}, 8'h00);

    // bit2 falls with clear asserted in the update cycle: set wins
    gp_raw = 8'h21;
    at_edge(5);
    irq_clr = 1'b1;
    at_edge(1);
    irq_clr = 1'b0;
    chk("fall_gp", gp_o, 8'h21);
    chk("fall_pulse", fall_o, EDGE_EN ? 8'h04 : 8'h00);
    chk("set_wins_irq", {7'b0, irq_o}, EDGE_EN ? 8'h01 : 8'h00);

    irq_clr = 1'b1; at_edge(1); irq_clr = 1'b0;
    chk("irq_cleared2", {7'b0, irq_o}, 8'h00);

    // masked bit6 edge
    gp_raw = 8'h61;
    at_edge(6);
    chk("masked_gp", gp_o, 8'h61);
    chk("masked_rise", rise_o, EDGE_EN ? 8'h40 : 8'h00);
    chk("masked_irq", {7'b0, irq_o}, 8'h00);

    // reset mid-count discards progress
    gp_raw = 8'h60;
    at_edge(3);
    rst_n = 1'b0;
    at_edge(1);
    chk("midreset_gp", gp_o, 8'h00);
    rst_n = 1'b1;
    at_edge(5);
    chk("after_reset_edge4_gp", gp_o, 8'h00);
    at_edge(1);
    chk("after_reset_edge5_gp", gp_o, 8'h60);

    at_edge(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
